// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) responder with a byte-wide client interface.
//
// SCL/SDA are oversampled on clk (clk >= 10x SCL) through a 2-flop
// synchronizer plus a 1-flop delay stage used for edge/START/STOP detection.
// A 7-bit address is matched and ACKed; the transfer then either receives
// write bytes (delivered on target_data_rx / target_rx_valid) or transmits
// read bytes (requested with target_tx_req, sampled from target_data_tx on
// the following SCL fall). SDA is driven open-drain style: SDA_out=0 pulls
// the line low, SDA_out=1 releases it. SCL is never driven (no stretching).
//
// Ports:
//   clk, rst_n       local clock, asynchronous active-low reset
//   SCL_in, SDA_in   bus levels
//   SDA_out          0 = pull SDA low, 1 = release
//   target_data_tx   read byte from client, sampled when it is loaded
//   target_tx_req    1-cycle pulse: client should present the next read byte
//   target_data_rx   last received write byte
//   target_rx_valid  1-cycle pulse when target_data_rx updates
//   addressed        high from address ACK until STOP, START or NACK exit
//   rw_dir           R/W bit of the current transfer (1 = read)
//   start_state      1-cycle pulse on START / repeated START
//   stop_state       1-cycle pulse on STOP
//
// Optional feature macro: I2C_TARGET_GENERAL_CALL_EN
//   When defined, address 7'h00 with R/W=0 (general call) is also ACKed.
//   7'h00 with R/W=1 is never ACKed.
`timescale 1ns/1ps

module i2c_target #(
    parameter int                         ADDRESS_WIDTH = 7,
    parameter int                         DATA_WIDTH    = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   ADDRESS       = 7'h10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCL_in,
    input  logic                  SDA_in,
    output logic                  SDA_out,
    input  logic [DATA_WIDTH-1:0] target_data_tx,
    output logic                  target_tx_req,
    output logic [DATA_WIDTH-1:0] target_data_rx,
    output logic                  target_rx_valid,
    output logic                  addressed,
    output logic                  rw_dir,
    output logic                  start_state,
    output logic                  stop_state
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_DATA,
        WRITE_ACK,
        READ_DATA,
        READ_ACK,
        IGNORE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [2:0]              bit_cnt;
    logic                    byte_done;   // 8 bits shifted in, waiting for the SCL fall
    logic                    ack_clk;     // ACK-bit SCL rise seen, act on the next fall
    logic                    ctrl_ack;    // controller ACKed the last read byte

    // Input conditioning. Reset to 1 so the idle bus does not look like an edge.
    logic scl_meta, scl_sync, scl_prev;
    logic sda_meta, sda_sync, sda_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= SCL_in;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= SDA_in;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  =  scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync &  scl_prev;
    // SDA edges only count as bus conditions while SCL is stably high.
    assign start_det =  scl_sync &  scl_prev &  sda_prev & ~sda_sync;
    assign stop_det  =  scl_sync &  scl_prev & ~sda_prev &  sda_sync;

    // Address decode of the byte just shifted in: {addr[6:0], rw}.
    logic [ADDRESS_WIDTH-1:0] rx_addr;
    logic                     rx_rw;
    logic                     addr_hit;

    assign rx_addr = shreg[DATA_WIDTH-1 -: ADDRESS_WIDTH];
    assign rx_rw   = shreg[0];

`ifdef I2C_TARGET_GENERAL_CALL_EN
    assign addr_hit = (rx_addr == ADDRESS) || ((rx_addr == '0) && !rx_rw);
`else
    assign addr_hit = (rx_addr == ADDRESS);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            SDA_out         <= 1'b1;
            target_tx_req   <= 1'b0;
            target_rx_valid <= 1'b0;
            target_data_rx  <= '0;
            addressed       <= 1'b0;
            rw_dir          <= 1'b0;
            start_state     <= 1'b0;
            stop_state      <= 1'b0;
            shreg           <= '0;
            bit_cnt         <= '0;
            byte_done       <= 1'b0;
            ack_clk         <= 1'b0;
            ctrl_ack        <= 1'b0;
        end else begin
            target_tx_req   <= 1'b0;
            target_rx_valid <= 1'b0;
            start_state     <= 1'b0;
            stop_state      <= 1'b0;

            if (start_det) begin
                // START or repeated START from any state
                start_state <= 1'b1;
                SDA_out     <= 1'b1;
                addressed   <= 1'b0;
                bit_cnt     <= '0;
                byte_done   <= 1'b0;
                ack_clk     <= 1'b0;
                state       <= ADDR;
            end else if (stop_det) begin
                // STOP drops any partial byte without a valid pulse
                stop_state  <= 1'b1;
                SDA_out     <= 1'b1;
                addressed   <= 1'b0;
                bit_cnt     <= '0;
                byte_done   <= 1'b0;
                ack_clk     <= 1'b0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        SDA_out <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= {shreg[DATA_WIDTH-2:0], sda_sync};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            bit_cnt   <= '0;
                            if (addr_hit) begin
                                SDA_out   <= 1'b0;
                                rw_dir    <= rx_rw;
                                addressed <= 1'b1;
                                state     <= ADDR_ACK;
                            end else begin
                                state     <= IGNORE;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_rise) begin
                            ack_clk <= 1'b1;
                            if (rw_dir) target_tx_req <= 1'b1;
                        end else if (scl_fall && ack_clk) begin
                            ack_clk <= 1'b0;
                            bit_cnt <= '0;
                            if (rw_dir) begin
                                shreg   <= target_data_tx;
                                SDA_out <= target_data_tx[DATA_WIDTH-1];
                                state   <= READ_DATA;
                            end else begin
                                SDA_out <= 1'b1;
                                state   <= WRITE_DATA;
                            end
                        end
                    end

                    WRITE_DATA: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= {shreg[DATA_WIDTH-2:0], sda_sync};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done       <= 1'b0;
                            bit_cnt         <= '0;
                            target_data_rx  <= shreg;
                            target_rx_valid <= 1'b1;
                            SDA_out         <= 1'b0;
                            state           <= WRITE_ACK;
                        end
                    end

                    WRITE_ACK: begin
                        if (scl_rise) begin
                            ack_clk <= 1'b1;
                        end else if (scl_fall && ack_clk) begin
                            ack_clk <= 1'b0;
                            SDA_out <= 1'b1;
                            state   <= WRITE_DATA;
                        end
                    end

                    READ_DATA: begin
                        // MSB was already driven on entry; each fall moves to the next bit.
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                SDA_out <= 1'b1;
                                bit_cnt <= '0;
                                state   <= READ_ACK;
                            end else begin
                                shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                                SDA_out <= shreg[DATA_WIDTH-2];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    READ_ACK: begin
                        if (scl_rise) begin
                            ack_clk  <= 1'b1;
                            ctrl_ack <= ~sda_sync;
                            if (!sda_sync) target_tx_req <= 1'b1;
                        end else if (scl_fall && ack_clk) begin
                            ack_clk <= 1'b0;
                            if (ctrl_ack) begin
                                shreg   <= target_data_tx;
                                SDA_out <= target_data_tx[DATA_WIDTH-1];
                                bit_cnt <= '0;
                                state   <= READ_DATA;
                            end else begin
                                addressed <= 1'b0;
                                state     <= IGNORE;
                            end
                        end
                    end

                    IGNORE: begin
                        SDA_out <= 1'b1;
                    end

                    default: begin
                        SDA_out <= 1'b1;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: randomized scoreboard bench for i2c_target.
// A bus-level controller model drives SCL and its half of the wired-AND SDA.
// Expected write bytes and read bytes are queued at transaction level and a
// monitor process pops/compares them as the DUT presents them.
`timescale 1ns/1ps

module tb_i2c_target;

    localparam logic [6:0] OWN = 7'h10;
`ifdef I2C_TARGET_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       ctrl_sda = 1'b1;
    logic [7:0] target_data_tx = 8'h00;
    logic       bus_sda;
    logic       SDA_out, target_tx_req, target_rx_valid, addressed, rw_dir;
    logic       start_state, stop_state;
    logic [7:0] target_data_rx;

    assign bus_sda = ctrl_sda & SDA_out;

    i2c_target #(.ADDRESS(OWN)) dut (
        .clk(clk), .rst_n(rst_n), .SCL_in(scl), .SDA_in(bus_sda),
        .SDA_out(SDA_out), .target_data_tx(target_data_tx),
        .target_tx_req(target_tx_req), .target_data_rx(target_data_rx),
        .target_rx_valid(target_rx_valid), .addressed(addressed),
        .rw_dir(rw_dir), .start_state(start_state), .stop_state(stop_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cnt_start = 0, cnt_stop = 0, cnt_req = 0, cnt_rx = 0;
    logic [7:0] rx_exp[$], rd_exp[$], rd_obs[$], tx_src[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: counts pulses, feeds read bytes, compares outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (start_state) cnt_start++;
                if (stop_state)  cnt_stop++;
                if (target_tx_req) begin
                    cnt_req++;
                    target_data_tx = (tx_src.size() > 0) ? tx_src.pop_front() : 8'hEE;
                end
                if (target_rx_valid) begin
                    cnt_rx++;
                    if (rx_exp.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL rx_unexpected: got %0h expected none", target_data_rx);
                    end else begin
                        check("rx_data", target_data_rx, rx_exp.pop_front());
                    end
                end
                while (rd_obs.size() > 0) begin
                    if (rd_exp.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL rd_unexpected: got %0h expected none", rd_obs.pop_front());
                    end else begin
                        check("rd_data", rd_obs.pop_front(), rd_exp.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Controller bus primitives; every bit starts and ends with SCL low.
    task automatic bit_out(input bit b);
        tick(5); ctrl_sda = b; tick(15); scl = 1'b1; tick(20); scl = 1'b0;
    endtask

    task automatic bit_in(output bit b);
        tick(5); ctrl_sda = 1'b1; tick(15); scl = 1'b1; tick(10); b = bus_sda; tick(10); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] d);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
    endtask

    task automatic send_start(input bit rep);
        if (rep) begin
            tick(5); ctrl_sda = 1'b1; tick(15); scl = 1'b1;
        end
        tick(20); ctrl_sda = 1'b0; tick(20); scl = 1'b0;
    endtask

    task automatic send_stop();
        tick(5); ctrl_sda = 1'b0; tick(15); scl = 1'b1; tick(20); ctrl_sda = 1'b1; tick(20);
    endtask

    // One transfer; expectations come from the addressing rules alone.
    task automatic xfer(input bit rep, input logic [6:0] a, input bit rw, input int n,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input bit do_stop);
        logic [7:0] d[3];
        logic [7:0] b;
        bit hit, ack;
        int s0, q0, x0, p0;
        d[0] = d0; d[1] = d1; d[2] = d2;
        hit = (a == OWN) || (GC && a == 7'h00 && !rw);
        s0 = cnt_start; q0 = cnt_req; x0 = cnt_rx;
        if (rw && hit)
            for (int i = 0; i < n; i++) begin
                tx_src.push_back(d[i]);
                rd_exp.push_back(d[i]);
            end
        send_start(rep);
        check("start_pulse", cnt_start - s0, 1);
        write_byte({a, rw}, ack);
        check("addr_ack", ack, !hit);
        check("addressed", addressed, hit);
        if (hit) check("rw_dir", rw_dir, rw);
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                if (hit) rx_exp.push_back(d[i]);
                write_byte(d[i], ack);
                check("data_ack", ack, !hit);
            end
            tick(10);
            check("rx_count", cnt_rx - x0, hit ? n : 0);
        end else if (hit) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, b);
                rd_obs.push_back(b);
            end
            tick(10);
            check("tx_req_count", cnt_req - q0, n);
            check("addressed_after_nack", addressed, 0);
        end
        if (do_stop) begin
            p0 = cnt_stop;
            send_stop();
            check("stop_pulse", cnt_stop - p0, 1);
            check("addressed_after_stop", addressed, 0);
        end
    endtask

    initial begin
        bit ack, b, rep, stp;
        logic [6:0] a;
        int sel;

        // Reset values
        tick(3);
        check("rst_sda_out", SDA_out, 1);
        check("rst_tx_req", target_tx_req, 0);
        check("rst_rx_valid", target_rx_valid, 0);
        check("rst_addressed", addressed, 0);
        check("rst_rw_dir", rw_dir, 0);
        check("rst_start", start_state, 0);
        check("rst_stop", stop_state, 0);
        check("rst_data_rx", target_data_rx, 0);
        rst_n = 1'b1;
        tick(20);

        // Directed cases
        xfer(0, OWN, 0, 1, 8'hA5, 8'h00, 8'h00, 1);
        xfer(0, 7'h11, 0, 2, 8'h12, 8'h34, 8'h00, 1);
        xfer(0, OWN, 1, 2, 8'h3C, 8'hF0, 8'h00, 1);
        xfer(0, OWN, 0, 1, 8'h55, 8'h00, 8'h00, 0);
        xfer(1, OWN, 1, 1, 8'h81, 8'h00, 8'h00, 1);
        xfer(0, 7'h00, 0, 1, 8'h06, 8'h00, 8'h00, 1);
        xfer(0, 7'h00, 1, 1, 8'h99, 8'h00, 8'h00, 1);

        // Reset while the target drives a 0 read bit
        tx_src.push_back(8'h00);
        send_start(0);
        write_byte({OWN, 1'b1}, ack);
        check("rstmid_addr_ack", ack, 0);
        bit_in(b);
        bit_in(b);
        tick(10);
        check("rstmid_pre_drive", SDA_out, 0);
        rst_n = 1'b0;
        #1;
        check("rstmid_sda_out", SDA_out, 1);
        check("rstmid_addressed", addressed, 0);
        check("rstmid_rw_dir", rw_dir, 0);
        check("rstmid_tx_req", target_tx_req, 0);
        check("rstmid_data_rx", target_data_rx, 0);
        tick(3); ctrl_sda = 1'b1; tick(5); scl = 1'b1; tick(10);
        rst_n = 1'b1;
        tick(20);

        // Randomized transfers
        rep = 1'b0;
        for (int t = 0; t < 14; t++) begin
            sel = $urandom_range(0, 7);
            a = (sel < 4) ? OWN : (sel == 4) ? 7'h11 : (sel == 5) ? 7'h00 : 7'($urandom);
            stp = (t == 13) ? 1'b1 : 1'($urandom_range(0, 1));
            xfer(rep, a, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                 8'($urandom), 8'($urandom), 8'($urandom), stp);
            rep = !stp;
        end

        tick(50);
        check("rx_exp_drained", rx_exp.size(), 0);
        check("rd_exp_drained", rd_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the far end of the I2C controller on the same bus.
- Oversamples SCL/SDA on the local clock and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs it, then either receives write bytes or transmits read bytes. The SDA drive is open-drain style.
- Sits on the system side of the bus and talks to a local register/FIFO client through a simple byte interface.

Parameters:
- ADDRESS, 7'h10, own 7-bit target address.
- ADDRESS_WIDTH, 7, address width; only 7 is supported.
- DATA_WIDTH, 8, byte width; only 8 is supported.

Ports:
- clk  input  1  local clock, at least 10x the SCL rate.
- rst_n  input  1  asynchronous active-low reset.
- SCL_in  input  1  bus SCL level.
- SDA_in  input  1  bus SDA level.
- SDA_out  output  1  0 = pull SDA low, 1 = release.
- target_data_tx  input  DATA_WIDTH  byte to send on a read; sampled on the load event.
- target_tx_req  output  1  one-cycle pulse requesting the next read byte.
- target_data_rx  output  DATA_WIDTH  last received write byte.
- target_rx_valid  output  1  one-cycle pulse when target_data_rx is updated.
- addressed  output  1  high from address ACK until STOP, START or NACK-exit.
- rw_dir  output  1  R/W bit of the current transfer (1 = read).
- start_state  output  1  one-cycle pulse on START or repeated START.
- stop_state  output  1  one-cycle pulse on STOP.

Behaviour:
- Reset values: SDA_out=1; target_tx_req=0; target_rx_valid=0; addressed=0; rw_dir=0; start_state=0; stop_state=0; target_data_rx=0; state=IDLE.
- Reset asserted mid-transfer releases SDA immediately.
- Input conditioning:
  - SCL_in and SDA_in each pass through a 2-flop synchronizer, then a 1-flop delay for edge detection.
  - Detection latency is 3 clk from pin to event.
- Bus events:
  - scl_rise / scl_fall: edges of the synchronized SCL.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - START/STOP take priority over bit sampling in the same cycle.
- Bit timing: SDA is sampled on scl_rise; SDA_out changes only on scl_fall. The exception is START/STOP, which release SDA at once.
- A 3-bit counter counts bits 0..7 within a byte. A shift register is MSB first.
- States:
  - IDLE: SDA released; START -> ADDR.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - On the scl_fall after bit 7: if addr==ADDRESS, drive SDA_out=0, latch rw_dir, set addressed, go to ADDR_ACK.
    - Otherwise go to IGNORE.
  - ADDR_ACK: on scl_rise, if rw_dir=1, pulse target_tx_req. On the next scl_fall:
    - read: load target_data_tx into the shift register, drive its MSB, go to READ_DATA.
    - write: release SDA, go to WRITE_DATA.
  - WRITE_DATA: shift 8 bits. On the scl_fall after bit 7: update target_data_rx, pulse target_rx_valid, drive SDA_out=0, go to WRITE_ACK.
  - WRITE_ACK: on scl_fall, release SDA, go to WRITE_DATA.
  - READ_DATA: on each scl_fall, drive the next bit. On the scl_fall after bit 7, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on scl_rise.
    - SDA=0 (controller ACK): pulse target_tx_req; on scl_fall load and drive the next MSB; go to READ_DATA.
    - SDA=1 (NACK): on scl_fall clear addressed and go to IGNORE.
  - IGNORE: SDA released; ignore bits; START -> ADDR, STOP -> IDLE.
- START in any state (repeated START): pulse start_state, release SDA, clear addressed, reset the bit counter, go to ADDR.
- STOP in any state: pulse stop_state, release SDA, clear addressed, go to IDLE. A partial byte is discarded and no rx_valid pulse is produced.
- The target never drives SCL; no clock stretching.

Optional Feature:
- Macro: I2C_TARGET_GENERAL_CALL_EN.
- Defined: address 7'h00 with R/W=0 is also ACKed; addressed=1 and write bytes are delivered as normal. Address 7'h00 with R/W=1 is NACKed and goes to IGNORE.
- Undefined: 7'h00 is treated as any non-matching address and goes to IGNORE.

Test Plan:
- START, address 0x10+W, byte 0xA5, STOP -> SDA held low during both ACK bits; target_rx_valid one pulse with target_data_rx=0xA5; stop_state pulse; addressed=0 after STOP.
- START, address 0x11+W -> SDA_out stays 1 for the whole frame; addressed=0; no rx_valid pulse; IGNORE until STOP.
- START, 0x10+R, target_data_tx=0x3C then 0xF0, controller ACKs byte 1 and NACKs byte 2:
  - SDA_out serializes 0x3C then 0xF0.
  - target_tx_req pulses exactly twice.
  - SDA is released after the NACK; state goes IGNORE then IDLE on STOP.
- Write 0x10+W, byte 0x55, repeated START, 0x10+R, read 0x81 -> start_state pulses twice; rw_dir changes 0->1; rx 0x55 delivered; 0x81 transmitted.
- Reset asserted while target drives a 0 read bit -> SDA_out=1 within the same cycle; all outputs at reset values.
- With I2C_TARGET_GENERAL_CALL_EN: START, 0x00+W, byte 0x06 -> ACK driven; target_data_rx=0x06. Without the macro: no ACK.
